pong_score_fsm: RTL and testbench

//  Match controller downstream of the ball stage: watches ball_y each game tick, detects goals past either paddle,

---
 rtl/pong_pkg.sv | 21 ++
 rtl/pong_key_edge.sv | 38 +++
 rtl/pong_score_fsm.sv | 150 +++++++++++++++
 tb/tb_pong_score_fsm.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared Pong definitions: match FSM states, player encoding and screen geometry.
package pong_pkg;

    localparam int LCD_WIDTH  = 240;
    localparam int LCD_HEIGHT = 320;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SERVE     = 3'd1,
        PLAY      = 3'd2,
        POINT     = 3'd3,
        GAME_OVER = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        P_NONE = 2'b00,
        P1     = 2'b01,
        P2     = 2'b10
    } player_t;

endpackage

// File: rtl/pong_key_edge.sv
// Synchroniser and press detector for an active-low push-button; press is one clock wide,
// three clocks after the pin falls.
module pong_key_edge (
    input  logic clock,
    input  logic resetApp,
    input  logic key_n,
    output logic press
);

    logic sync_1;
    logic sync_2;
    logic sync_2_d;
    logic valid_1;
    logic valid_2;
    logic armed;

    // A key held through reset must be seen released before a press can count.
    always_ff @(posedge clock or posedge resetApp) begin
        if (resetApp) begin
            sync_1   <= 1'b1;
            sync_2   <= 1'b1;
            sync_2_d <= 1'b1;
            valid_1  <= 1'b0;
            valid_2  <= 1'b0;
            armed    <= 1'b0;
            press    <= 1'b0;
        end else begin
            sync_1   <= key_n;
            sync_2   <= sync_1;
            sync_2_d <= sync_2;
            valid_1  <= 1'b1;
            valid_2  <= valid_1;
            armed    <= armed | (valid_2 & sync_2);
            press    <= armed & sync_2_d & ~sync_2;
        end
    end

endmodule

// File: rtl/pong_score_fsm.sv
// Pong match controller: goal detection, scoring, serve timing and game-over handling.
// Optional auto-restart from GAME_OVER is enabled by defining PONG_AUTO_RESTART_EN.
module pong_score_fsm
    import pong_pkg::*;
#(
    parameter int MAX_SCORE   = 10,
    parameter int TOP_LINE    = 8,
    parameter int BOT_LINE    = LCD_HEIGHT - 9,
    parameter int SERVE_TICKS = 60
`ifdef PONG_AUTO_RESTART_EN
    ,
    parameter int RESTART_TICKS = 150
`endif
) (
    input  logic       clock,
    input  logic       resetApp,
    input  logic       game_tick,
    input  logic [8:0] ball_y,
    input  logic       start_n,
    output logic [3:0] score_1,
    output logic [3:0] score_2,
    output logic       ball_hold,
    output logic       serve_dir,
    output logic       point_pulse,
    output logic       game_over,
    output logic [1:0] winner,
    output logic [2:0] state_dbg
);

    localparam int             CW         = $clog2(SERVE_TICKS + 1);
    localparam logic [CW-1:0]  SERVE_LOAD = CW'(SERVE_TICKS - 1);

    state_t        state;
    player_t       scorer;
    logic [CW-1:0] serve_cnt;
    logic          start_evt;
    logic          restart;

    pong_key_edge u_start_key (
        .clock    (clock),
        .resetApp (resetApp),
        .key_n    (start_n),
        .press    (start_evt)
    );

`ifdef PONG_AUTO_RESTART_EN
    localparam int             RW           = $clog2(RESTART_TICKS + 1);
    localparam logic [RW-1:0]  RESTART_LAST = RW'(RESTART_TICKS - 1);

    logic [RW-1:0] restart_cnt;

    // Counts game ticks spent in GAME_OVER; cleared whenever the match is not over.
    always_ff @(posedge clock or posedge resetApp) begin
        if (resetApp) begin
            restart_cnt <= '0;
        end else if (state != GAME_OVER || restart) begin
            restart_cnt <= '0;
        end else if (game_tick) begin
            restart_cnt <= restart_cnt + 1'b1;
        end
    end

    assign restart = start_evt || (state == GAME_OVER && game_tick && restart_cnt == RESTART_LAST);
`else
    assign restart = start_evt;
`endif

    assign state_dbg = state;

    always_ff @(posedge clock or posedge resetApp) begin
        if (resetApp) begin
            state       <= IDLE;
            scorer      <= P_NONE;
            serve_cnt   <= '0;
            score_1     <= 4'd0;
            score_2     <= 4'd0;
            ball_hold   <= 1'b1;
            serve_dir   <= 1'b0;
            point_pulse <= 1'b0;
            game_over   <= 1'b0;
            winner      <= P_NONE;
        end else begin
            point_pulse <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start_evt) begin
                        state     <= SERVE;
                        score_1   <= 4'd0;
                        score_2   <= 4'd0;
                        serve_cnt <= SERVE_LOAD;
                    end
                end
                SERVE: begin
                    if (game_tick) begin
                        if (serve_cnt == '0) begin
                            state     <= PLAY;
                            ball_hold <= 1'b0;
                        end else begin
                            serve_cnt <= serve_cnt - 1'b1;
                        end
                    end
                end
                PLAY: begin
                    // Score and pulse land on the same edge that enters POINT.
                    if (game_tick && ball_y < 9'(TOP_LINE)) begin
                        state       <= POINT;
                        scorer      <= P1;
                        score_1     <= score_1 + 4'd1;
                        serve_dir   <= 1'b0;
                        point_pulse <= 1'b1;
                        ball_hold   <= 1'b1;
                    end else if (game_tick && ball_y > 9'(BOT_LINE)) begin
                        state       <= POINT;
                        scorer      <= P2;
                        score_2     <= score_2 + 4'd1;
                        serve_dir   <= 1'b1;
                        point_pulse <= 1'b1;
                        ball_hold   <= 1'b1;
                    end
                end
                POINT: begin
                    if (((scorer == P1) ? score_1 : score_2) == 4'(MAX_SCORE)) begin
                        state     <= GAME_OVER;
                        game_over <= 1'b1;
                        winner    <= scorer;
                    end else begin
                        state     <= SERVE;
                        serve_cnt <= SERVE_LOAD;
                    end
                end
                GAME_OVER: begin
                    if (restart) begin
                        state     <= SERVE;
                        score_1   <= 4'd0;
                        score_2   <= 4'd0;
                        winner    <= P_NONE;
                        serve_dir <= 1'b0;
                        game_over <= 1'b0;
                        serve_cnt <= SERVE_LOAD;
                    end
                end
                default: begin
                    state     <= IDLE;
                    ball_hold <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pong_score_fsm.sv
// Directed bench for pong_score_fsm; expected values are hand-computed from the match rules.
module tb_pong_score_fsm;

    logic       clock = 1'b0;
    logic       resetApp;
    logic       game_tick;
    logic [8:0] ball_y;
    logic       start_n;
    logic [3:0] score_1;
    logic [3:0] score_2;
    logic       ball_hold;
    logic       serve_dir;
    logic       point_pulse;
    logic       game_over;
    logic [1:0] winner;
    logic [2:0] state_dbg;

    int checks = 0;
    int passed = 0;
    int failed = 0;
    int lat;

    pong_score_fsm dut (
        .clock       (clock),
        .resetApp    (resetApp),
        .game_tick   (game_tick),
        .ball_y      (ball_y),
        .start_n     (start_n),
        .score_1     (score_1),
        .score_2     (score_2),
        .ball_hold   (ball_hold),
        .serve_dir   (serve_dir),
        .point_pulse (point_pulse),
        .game_over   (game_over),
        .winner      (winner),
        .state_dbg   (state_dbg)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One-clock game_tick carrying ball_y; called and returns on a falling edge.
    task automatic tick(input logic [8:0] y);
        ball_y    = y;
        game_tick = 1'b1;
        @(negedge clock);
        game_tick = 1'b0;
    endtask

    // Hold start_n low for 5 clocks; lat = clocks until SERVE is seen (0 if never within 8).
    task automatic press_start(output int l);
        l = 0;
        start_n = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clock);
            if (state_dbg == 3'd1 && l == 0) l = i;
            if (i == 5) start_n = 1'b1;
        end
    endtask

    task automatic serve_to_play();
        repeat (60) tick(9'd160);
        chk("serve_to_play", int'(state_dbg), 2);
    endtask

    initial begin
        resetApp  = 1'b1;
        start_n   = 1'b1;
        game_tick = 1'b0;
        ball_y    = 9'd160;
        repeat (3) @(negedge clock);
        chk("rst_state", int'(state_dbg), 0);
        chk("rst_scores", int'({score_1, score_2}), 0);
        chk("rst_hold", int'(ball_hold), 1);
        chk("rst_flags", int'({serve_dir, point_pulse, game_over, winner}), 0);
        resetApp = 1'b0;
        repeat (3) @(negedge clock);

        press_start(lat);
        chk("start_latency", lat, 4);
        chk("serve_hold", int'(ball_hold), 1);

        repeat (59) tick(9'd160);
        chk("serve_59", int'(state_dbg), 1);
        chk("hold_59", int'(ball_hold), 1);
        tick(9'd160);
        chk("play_60", int'(state_dbg), 2);
        chk("play_hold", int'(ball_hold), 0);

        // Top goal: player 1 scores.
        tick(9'd5);
        chk("p1_point_state", int'(state_dbg), 3);
        chk("p1_point_pulse", int'(point_pulse), 1);
        chk("p1_score", int'(score_1), 1);
        chk("p1_serve_dir", int'(serve_dir), 0);
        @(negedge clock);
        chk("p1_back_serve", int'(state_dbg), 1);
        chk("p1_pulse_end", int'(point_pulse), 0);

        // Bottom position without a tick does nothing; with a tick, player 2 scores.
        serve_to_play();
        ball_y = 9'd312;
        repeat (3) @(negedge clock);
        chk("no_tick_state", int'(state_dbg), 2);
        chk("no_tick_score2", int'(score_2), 0);
        tick(9'd312);
        chk("p2_point_state", int'(state_dbg), 3);
        chk("p2_score", int'(score_2), 1);
        chk("p2_serve_dir", int'(serve_dir), 1);
        chk("p2_pulse", int'(point_pulse), 1);
        @(negedge clock);
        chk("p2_back_serve", int'(state_dbg), 1);

        // Lines themselves are not goals; one pixel past is.
        serve_to_play();
        tick(9'd8);
        chk("top_line", int'(state_dbg), 2);
        tick(9'd311);
        chk("bot_line", int'(state_dbg), 2);
        chk("lines_scores", int'({score_1, score_2}), 8'h11);
        tick(9'd7);
        chk("top_past", int'(score_1), 2);
        @(negedge clock);

        // Player 2 to 9, then the winning goal.
        for (int k = 0; k < 8; k++) begin
            serve_to_play();
            tick(9'd315);
            @(negedge clock);
        end
        chk("p2_at_9", int'(score_2), 9);
        serve_to_play();
        tick(9'd315);
        chk("win_score2", int'(score_2), 10);
        @(negedge clock);
        chk("win_state", int'(state_dbg), 4);
        chk("win_game_over", int'(game_over), 1);
        chk("win_winner", int'(winner), 2);
        chk("win_hold", int'(ball_hold), 1);
        repeat (5) tick(9'd0);
        chk("over_frozen_state", int'(state_dbg), 4);
        chk("over_frozen_scores", int'({score_1, score_2}), 8'h2A);
        chk("over_no_pulse", int'(point_pulse), 0);

        press_start(lat);
        chk("restart_latency", lat, 4);
        chk("restart_scores", int'({score_1, score_2}), 0);
        chk("restart_flags", int'({serve_dir, game_over, winner}), 0);

        // Reset mid-play with the button held down.
        serve_to_play();
        tick(9'd0);
        @(negedge clock);
        serve_to_play();
        start_n  = 1'b0;
        resetApp = 1'b1;
        #1;
        chk("async_rst_state", int'(state_dbg), 0);
        @(negedge clock);
        resetApp = 1'b0;
        repeat (10) @(negedge clock);
        chk("held_state", int'(state_dbg), 0);
        chk("held_scores", int'({score_1, score_2}), 0);
        chk("held_hold", int'(ball_hold), 1);
        start_n = 1'b1;
        repeat (3) @(negedge clock);
        press_start(lat);
        chk("after_release_latency", lat, 4);

        // Player 1 wins 10-0, then GAME_OVER timeout behaviour.
        for (int k = 0; k < 10; k++) begin
            serve_to_play();
            tick(9'd0);
            @(negedge clock);
        end
        chk("p1_win_state", int'(state_dbg), 4);
        chk("p1_win_winner", int'(winner), 1);
        chk("p1_win_score", int'(score_1), 10);
`ifdef PONG_AUTO_RESTART_EN
        repeat (149) tick(9'd160);
        chk("auto_149", int'(state_dbg), 4);
        tick(9'd160);
        chk("auto_150", int'(state_dbg), 1);
        chk("auto_scores", int'({score_1, score_2}), 0);
        chk("auto_winner", int'(winner), 0);
`else
        repeat (1000) tick(9'd160);
        chk("hold_1000", int'(state_dbg), 4);
        chk("hold_1000_winner", int'(winner), 1);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
